// File: rtl/reloj_pkg.sv
// reloj_pkg: shared field limits, campo_sel encodings and FSM states for contador_reloj_hms.
package reloj_pkg;
  localparam int MAX_SEG = 59;
  localparam int MAX_MIN = 59;
  localparam logic [1:0] CAMPO_SEG     = 2'd0;
  localparam logic [1:0] CAMPO_MIN     = 2'd1;
  localparam logic [1:0] CAMPO_HORA    = 2'd2;
  localparam logic [1:0] CAMPO_NINGUNO = 2'd3;
  typedef enum logic {CUENTA, AJUSTE} estado_t;
endpackage

// File: rtl/contador_mod.sv
// contador_mod: modulo-MOD up/down counter; carry flags an increment out of the terminal count.
module contador_mod #(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_inc,
  input  logic       en_dec,
  output logic [5:0] valor,
  output logic       carry
);
  localparam logic [5:0] MAXV = 6'(MOD - 1);
  assign carry = en_inc & ~en_dec & (valor == MAXV);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valor <= '0;
    else if (en_inc & ~en_dec) valor <= (valor == MAXV) ? '0 : valor + 6'd1;
    else if (en_dec & ~en_inc) valor <= (valor == '0) ? MAXV : valor - 6'd1;
endmodule

// File: rtl/contador_reloj_hms.sv
// contador_reloj_hms: run/adjust time-of-day counter (h:m:s) with day-wrap pulse.
// Optional alarm (ports alarma_h/alarma_m/alarma_ack/alarma) enabled by defining ALARMA_EN.
module contador_reloj_hms
  import reloj_pkg::*;
#(
  parameter int HORAS = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       modo_ajuste,
  input  logic [1:0] campo_sel,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [5:0] segundos,
  output logic [5:0] minutos,
  output logic [5:0] horas,
  output logic       fin_dia,
`ifdef ALARMA_EN
  input  logic [5:0] alarma_h,
  input  logic [5:0] alarma_m,
  input  logic       alarma_ack,
  output logic       alarma,
`endif
  output logic       en_ajuste
);
  estado_t estado, estado_nxt;
  logic inc_q, dec_q, ed_inc, ed_dec, cuenta;
  logic seg_inc, seg_dec, min_inc, min_dec, hora_inc, hora_dec;
  logic seg_c, min_c, hora_c;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      estado  <= CUENTA;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      fin_dia <= 1'b0;
    end else begin
      estado  <= estado_nxt;
      inc_q   <= btn_inc;
      dec_q   <= btn_dec;
      fin_dia <= cuenta & hora_c;
    end
  always_comb begin
    estado_nxt = modo_ajuste ? AJUSTE : CUENTA;
    cuenta     = (estado == CUENTA);
    ed_inc     = btn_inc & ~inc_q;
    ed_dec     = btn_dec & ~dec_q;
    seg_inc    = cuenta ? tick_1hz : ed_inc & (campo_sel == CAMPO_SEG);
    min_inc    = cuenta ? seg_c    : ed_inc & (campo_sel == CAMPO_MIN);
    hora_inc   = cuenta ? min_c    : ed_inc & (campo_sel == CAMPO_HORA);
    seg_dec    = ~cuenta & ed_dec & (campo_sel == CAMPO_SEG);
    min_dec    = ~cuenta & ed_dec & (campo_sel == CAMPO_MIN);
    hora_dec   = ~cuenta & ed_dec & (campo_sel == CAMPO_HORA);
  end
  assign en_ajuste = (estado == AJUSTE);
  contador_mod #(.MOD(MAX_SEG + 1)) u_seg (.clk(clk), .rst_n(rst_n), .en_inc(seg_inc), .en_dec(seg_dec), .valor(segundos), .carry(seg_c));
  contador_mod #(.MOD(MAX_MIN + 1)) u_min (.clk(clk), .rst_n(rst_n), .en_inc(min_inc), .en_dec(min_dec), .valor(minutos), .carry(min_c));
  contador_mod #(.MOD(HORAS)) u_hora (.clk(clk), .rst_n(rst_n), .en_inc(hora_inc), .en_dec(hora_dec), .valor(horas), .carry(hora_c));
`ifdef ALARMA_EN
  logic [5:0] min_nxt, hora_nxt;
  logic alarma_set;
  always_comb begin
    min_nxt    = min_c ? 6'd0 : (min_inc ? minutos + 6'd1 : minutos);
    hora_nxt   = hora_c ? 6'd0 : (hora_inc ? horas + 6'd1 : horas);
    alarma_set = cuenta & seg_c & (min_nxt == alarma_m) & (hora_nxt == alarma_h);
  end
  // set has priority over a simultaneous acknowledge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) alarma <= 1'b0;
    else alarma <= alarma_set | (alarma & ~alarma_ack);
`endif
endmodule

// File: tb/tb_contador_reloj_hms.sv
// tb_contador_reloj_hms: drives a 24-hour and a 12-hour instance with shared stimulus against a seconds-of-day model.
module tb_contador_reloj_hms;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, modo = 1'b0, bi = 1'b0, bd = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [5:0] s[2], m[2], h[2];
  logic fin[2], adj[2];
`ifdef ALARMA_EN
  logic [5:0] ah = 6'd63, am = 6'd0;
  logic ack = 1'b0;
  logic alm[2];
  bit malm[2];
`endif
  int ms[2], mm[2], mh[2];
  bit mfin[2], madj[2];
  bit pi, pd;
  int hm[2] = '{24, 12};
  int n_cmp = 0, n_bad = 0;

  contador_reloj_hms #(.HORAS(24)) u24 (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick), .modo_ajuste(modo), .campo_sel(sel),
    .btn_inc(bi), .btn_dec(bd), .segundos(s[0]), .minutos(m[0]), .horas(h[0]), .fin_dia(fin[0]),
`ifdef ALARMA_EN
    .alarma_h(ah), .alarma_m(am), .alarma_ack(ack), .alarma(alm[0]),
`endif
    .en_ajuste(adj[0]));
  contador_reloj_hms #(.HORAS(12)) u12 (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick), .modo_ajuste(modo), .campo_sel(sel),
    .btn_inc(bi), .btn_dec(bd), .segundos(s[1]), .minutos(m[1]), .horas(h[1]), .fin_dia(fin[1]),
`ifdef ALARMA_EN
    .alarma_h(ah), .alarma_m(am), .alarma_ack(ack), .alarma(alm[1]),
`endif
    .en_ajuste(adj[1]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input int exp);
    n_cmp++;
    assert (obs === 8'(exp)) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = 0; mm[k] = 0; mh[k] = 0; mfin[k] = 0; madj[k] = 0;
`ifdef ALARMA_EN
      malm[k] = 0;
`endif
    end
    pi = 0; pd = 0;
  endtask

  // Model: time held as seconds of day in run mode, plain modular field steps in adjust mode
  task automatic model_clk();
    bit ei, ed, set;
    ei = bi && !pi;
    ed = bd && !pd;
    for (int k = 0; k < 2; k++) begin
      mfin[k] = 0;
      set = 0;
      if (!madj[k]) begin
        if (tick) begin
          int t;
          t = ms[k] + 60 * mm[k] + 3600 * mh[k] + 1;
          mfin[k] = (t == hm[k] * 3600);
          t = t % (hm[k] * 3600);
          mh[k] = t / 3600; mm[k] = (t / 60) % 60; ms[k] = t % 60;
`ifdef ALARMA_EN
          set = (ms[k] == 0) && (mm[k] == int'(am)) && (mh[k] == int'(ah));
`endif
        end
      end else if (ei != ed) begin
        int d;
        d = ei ? 1 : -1;
        if (sel == 2'd0) ms[k] = (ms[k] + d + 60) % 60;
        else if (sel == 2'd1) mm[k] = (mm[k] + d + 60) % 60;
        else if (sel == 2'd2) mh[k] = (mh[k] + d + hm[k]) % hm[k];
      end
`ifdef ALARMA_EN
      malm[k] = set ? 1'b1 : (ack ? 1'b0 : malm[k]);
`endif
      madj[k] = modo;
    end
    pi = bi; pd = bd;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("seg_h%0d", hm[k]), {2'b0, s[k]}, ms[k]);
      chk($sformatf("min_h%0d", hm[k]), {2'b0, m[k]}, mm[k]);
      chk($sformatf("hora_h%0d", hm[k]), {2'b0, h[k]}, mh[k]);
      chk($sformatf("fin_dia_h%0d", hm[k]), {7'b0, fin[k]}, int'(mfin[k]));
      chk($sformatf("en_ajuste_h%0d", hm[k]), {7'b0, adj[k]}, int'(madj[k]));
`ifdef ALARMA_EN
      chk($sformatf("alarma_h%0d", hm[k]), {7'b0, alm[k]}, int'(malm[k]));
`endif
    end
  endtask

  task automatic step();
    model_clk();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic pulse_tick();
    tick = 1; step(); tick = 0; step();
  endtask

  task automatic press(input bit inc);
    if (inc) bi = 1; else bd = 1;
    step();
    bi = 0; bd = 0;
    step();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1;
    // run count: 59 then 60 ticks
    repeat (59) pulse_tick();
    chk("t1_seg59", {2'b0, s[0]}, 59);
    chk("t1_min0", {2'b0, m[0]}, 0);
    pulse_tick();
    chk("t1_seg0", {2'b0, s[0]}, 0);
    chk("t1_min1", {2'b0, m[0]}, 1);
    // preload last second of the day and wrap
    modo = 1; step();
    sel = 2'd0; press(0);
    sel = 2'd1; press(0); press(0);
    sel = 2'd2; press(0);
    chk("t2_hora23", {2'b0, h[0]}, 23);
    chk("t2_hora11", {2'b0, h[1]}, 11);
    modo = 0; step();
    tick = 1; step(); tick = 0;
    chk("t2_fin24", {7'b0, fin[0]}, 1);
    chk("t2_fin12", {7'b0, fin[1]}, 1);
    chk("t2_wrap_h", {2'b0, h[0]}, 0);
    step();
    chk("t2_fin_low", {7'b0, fin[0]}, 0);
    // adjust: wrap down, ticks ignored, held button single step
    modo = 1; step();
    sel = 2'd1; press(0);
    chk("t3_min59", {2'b0, m[0]}, 59);
    chk("t3_hora0", {2'b0, h[0]}, 0);
    repeat (3) pulse_tick();
    chk("t3_tick_ign", {2'b0, s[0]}, 0);
    bi = 1; repeat (10) step(); bi = 0; step();
    chk("t3_held", {2'b0, m[0]}, 0);
    // simultaneous edges and campo_sel none
    bi = 1; bd = 1; step(); bi = 0; bd = 0; step();
    sel = 2'd3; press(1); press(0);
    // async reset mid-adjust at 5:30:12
    sel = 2'd2; while (mh[0] != 5) press(1);
    sel = 2'd1; while (mm[0] != 30) press(1);
    sel = 2'd0; while (ms[0] != 12) press(1);
    @(posedge clk);
    #3 rst_n = 0;
    model_reset();
    #1 check_all();
    chk("t5_en_ajuste", {7'b0, adj[0]}, 0);
    @(negedge clk) rst_n = 1;
    modo = 0; step();
`ifdef ALARMA_EN
    ah = 6'd0; am = 6'd1;
    repeat (59) pulse_tick();
    chk("t6_alarma_pre", {7'b0, alm[0]}, 0);
    pulse_tick();
    chk("t6_alarma_set", {7'b0, alm[0]}, 1);
    repeat (3) step();
    ack = 1; step(); ack = 0;
    chk("t6_alarma_ack", {7'b0, alm[0]}, 0);
`endif
    // randomized mixed operation
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) modo = ~modo;
      tick = ($urandom_range(0, 1) == 0);
      bi = ($urandom_range(0, 3) == 0);
      bd = ($urandom_range(0, 3) == 0);
      sel = 2'($urandom_range(0, 3));
`ifdef ALARMA_EN
      ack = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) begin
        ah = 6'(mh[1]); am = 6'((mm[1] + 1) % 60);
      end
`endif
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
